uart_tx_arb: RTL and testbench

//   Shares one byte-wide UART transmitter among NUM_REQ requesters.

---
 rtl/uart_arb_pkg.sv | 14 +
 rtl/uart_rr_pick.sv | 30 +++
 rtl/uart_tx_arb.sv | 134 +++++++++++++
 tb/tb_uart_tx_arb.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared constants and FSM state type for the UART transmit arbiter.
package uart_arb_pkg;

    localparam int BYTE_W          = 8;
    localparam int DEF_TIMEOUT_CYC = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above ptr, with wrap.
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one byte-wide UART transmitter among NUM_REQ packet sources.
// Optional WAIT_BUSY timeout is compiled in with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int IDX_W       = 2,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [BYTE_W-1:0]         uart_tx_data,
    output logic                      uart_tx_send,
    input  logic                      uart_tx_busy,
    output logic [IDX_W-1:0]          grant_idx,
    output logic                      arb_busy,
    output logic                      arb_err
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << IDX_W) < NUM_REQ ||
        TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_param_err
        $error("uart_tx_arb: illegal parameter combination");
    end

    arb_state_t           state_q, state_d;
    logic                 lock_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [IDX_W-1:0]     idx_q;
    logic [BYTE_W-1:0]    data_q;
    logic [IDX_W-1:0]     idx_inc;
    logic [NUM_REQ-1:0]   eligible;
    logic [IDX_W-1:0]     pick_ptr;
    logic [NUM_REQ-1:0]   pick_grant;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic                 accept;
    logic                 timeout;

    // While a packet is locked only the owner may win; starting the search at
    // the owner keeps the picker identical for both cases.
    assign eligible = lock_q ? (req_valid & ({{(NUM_REQ-1){1'b0}}, 1'b1} << idx_q)) : req_valid;
    assign pick_ptr = lock_q ? idx_q : ptr_q;
    assign idx_inc  = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (eligible),
        .ptr   (pick_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

`ifdef UART_ARB_TIMEOUT_EN
    logic [7:0] to_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || state_q != WAIT_BUSY) begin
            to_cnt_q <= '0;
        end else if (!uart_tx_busy) begin
            to_cnt_q <= to_cnt_q + 8'd1;
        end
    end

    assign timeout = (state_q == WAIT_BUSY) && !uart_tx_busy &&
                     (to_cnt_q == 8'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any && !rst) begin
                    req_ready = pick_grant;
                    accept    = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND:      state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    state_d = IDLE;
                end
            end
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lock_q  <= 1'b0;
            ptr_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q <= req_data[pick_idx*BYTE_W +: BYTE_W];
                idx_q  <= pick_idx;
                lock_q <= ~req_last[pick_idx];
            end else if (timeout) begin
                lock_q <= 1'b0;
                ptr_q  <= idx_inc;
            end else if (state_q == WAIT_DONE && !uart_tx_busy && !lock_q) begin
                ptr_q  <= idx_inc;
            end
        end
    end

    assign uart_tx_send = (state_q == SEND);
    assign uart_tx_data = data_q;
    assign grant_idx    = idx_q;
    assign arb_busy     = (state_q != IDLE) || lock_q;
    assign arb_err      = timeout;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: packet-level round-robin model feeding an expected byte queue.
module tb_uart_tx_arb;
    import uart_arb_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           uart_tx_data;
    logic                 uart_tx_send;
    logic                 uart_tx_busy;
    logic [IDX_W-1:0]     grant_idx;
    logic                 arb_busy;
    logic                 arb_err;

    uart_tx_arb #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .uart_tx_data (uart_tx_data),
        .uart_tx_send (uart_tx_send),
        .uart_tx_busy (uart_tx_busy),
        .grant_idx    (grant_idx),
        .arb_busy     (arb_busy),
        .arb_err      (arb_err)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Requester byte sources and the scoreboard.
    logic [7:0]       src_data [NUM_REQ][$];
    logic             src_last [NUM_REQ][$];
    logic [NUM_REQ-1:0] hold = '0;
    logic [7:0]       exp_q[$];
    logic [IDX_W-1:0] exp_idx_q[$];

    // Model state at packet granularity.
    int m_ptr   = 0;
    int m_lock  = 0;
    int m_owner = 0;

    bit mute      = 1'b0;
    bit abort     = 1'b0;
    bit long_busy = 1'b0;

    task automatic push_byte(input int r, input logic [7:0] b, input logic l);
        src_data[r].push_back(b);
        src_last[r].push_back(l);
    endtask

    // Serve everything currently queued in arbitration order.
    task automatic model_append();
        logic [7:0] d [NUM_REQ][$];
        logic       l [NUM_REQ][$];
        int  w;
        bit  more;
        for (int i = 0; i < NUM_REQ; i++) begin
            d[i] = src_data[i];
            l[i] = src_last[i];
        end
        more = 1'b1;
        while (more) begin
            w = -1;
            if (m_lock != 0) begin
                if (d[m_owner].size() > 0) w = m_owner;
            end else begin
                for (int k = NUM_REQ - 1; k >= 0; k--) begin
                    if (d[(m_ptr + k) % NUM_REQ].size() > 0) w = (m_ptr + k) % NUM_REQ;
                end
            end
            if (w < 0) begin
                more = 1'b0;
            end else begin
                exp_q.push_back(d[w].pop_front());
                exp_idx_q.push_back(IDX_W'(w));
                m_owner = w;
                if (l[w].pop_front()) begin
                    m_lock = 0;
                    m_ptr  = (w + 1) % NUM_REQ;
                end else begin
                    m_lock = 1;
                end
            end
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_data[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Requester driver: accept sampled at negedge, source popped after the edge.
    initial begin : driver
        logic [NUM_REQ-1:0] acc;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            if (req_ready != '0) begin
                vectors++;
                if (!$onehot(req_ready) || (req_ready & ~req_valid) != '0) begin
                    miscompares++;
                    $display("FAIL ready_onehot: req_ready=%b req_valid=%b, required one-hot subset of valid",
                             req_ready, req_valid);
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i]) begin
                    void'(src_data[i].pop_front());
                    void'(src_last[i].pop_front());
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (src_data[i].size() > 0 && !hold[i]) begin
                    req_valid[i]      = 1'b1;
                    req_data[8*i +: 8] = src_data[i][0];
                    req_last[i]       = src_last[i][0];
                end else begin
                    req_valid[i]      = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]       = 1'b0;
                end
            end
        end
    end

    // Transmitter model and byte scoreboard.
    initial begin : uart_model
        logic [7:0]       cap, e;
        logic [IDX_W-1:0] ei;
        int dly, len;
        uart_tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_tx_send === 1'b1) begin
                cap = uart_tx_data;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_send: data=%h, required no send", cap);
                end else begin
                    e  = exp_q.pop_front();
                    ei = exp_idx_q.pop_front();
                    if (cap !== e || grant_idx !== ei) begin
                        miscompares++;
                        $display("FAIL send_byte: data=%h idx=%0d, required data=%h idx=%0d", cap, grant_idx, e, ei);
                    end
                end
                if (!mute) begin
                    dly = $urandom_range(1, 3);
                    len = long_busy ? 20 : $urandom_range(1, 6);
                    repeat (dly) @(posedge clk);
                    #1 uart_tx_busy = 1'b1;
                    for (int k = 0; k < len && !abort; k++) begin
                        @(negedge clk);
                        if (!rst && !abort) begin
                            vectors++;
                            if (uart_tx_data !== cap || uart_tx_send !== 1'b0) begin
                                miscompares++;
                                $display("FAIL data_stable: data=%h send=%b, required data=%h send=0",
                                         uart_tx_data, uart_tx_send, cap);
                            end
                        end
                    end
                    @(posedge clk);
                    #1 uart_tx_busy = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

    task automatic wait_drain(input string tag);
        int n = 0;
        while (n < 3000 && !(all_empty() && exp_q.size() == 0 && !arb_busy && !uart_tx_busy)) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 3000) begin
            miscompares++;
            $display("FAIL drain_%s: pending=%0d arb_busy=%b, required 0 pending and idle", tag, exp_q.size(), arb_busy);
        end
    endtask

    task automatic check_ptr(input string tag);
        vectors++;
        if (dut.ptr_q !== IDX_W'(m_ptr)) begin
            miscompares++;
            $display("FAIL ptr_%s: ptr=%0d, required %0d", tag, dut.ptr_q, m_ptr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors += 6;
        if (req_ready !== '0)    begin miscompares++; $display("FAIL rst_ready: %b, required 0", req_ready); end
        if (uart_tx_send !== 0)  begin miscompares++; $display("FAIL rst_send: %b, required 0", uart_tx_send); end
        if (uart_tx_data !== 0)  begin miscompares++; $display("FAIL rst_data: %h, required 00", uart_tx_data); end
        if (grant_idx !== 0)     begin miscompares++; $display("FAIL rst_idx: %0d, required 0", grant_idx); end
        if (arb_busy !== 0)      begin miscompares++; $display("FAIL rst_busy: %b, required 0", arb_busy); end
        if (arb_err !== 0)       begin miscompares++; $display("FAIL rst_err: %b, required 0", arb_err); end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single();
        int n = 0;
        push_byte(0, 8'h55, 1'b1);
        model_append();
        while (n < 20 && req_ready[0] !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 20) begin
            miscompares++;
            $display("FAIL single_ready: ready=%b, required ready[0]=1", req_ready);
        end
        @(negedge clk);
        vectors += 2;
        if (uart_tx_send !== 1'b1 || uart_tx_data !== 8'h55) begin
            miscompares++;
            $display("FAIL single_send: send=%b data=%h, required send=1 data=55", uart_tx_send, uart_tx_data);
        end
        if (req_ready !== '0) begin
            miscompares++;
            $display("FAIL single_ready_pulse: ready=%b, required 0", req_ready);
        end
        wait_drain("single");
        check_ptr("single");
    endtask

    task automatic test_lock_packet();
        push_byte(1, 8'h11, 1'b0);
        push_byte(1, 8'h12, 1'b0);
        push_byte(1, 8'h13, 1'b1);
        push_byte(2, 8'h2B, 1'b1);
        model_append();
        wait_drain("lock");
        check_ptr("lock");
    endtask

    task automatic test_hold_owner();
        int n = 0;
        push_byte(1, 8'h21, 1'b0);
        push_byte(1, 8'h22, 1'b0);
        push_byte(1, 8'h23, 1'b1);
        push_byte(2, 8'h2A, 1'b1);
        model_append();
        while (n < 100 && src_data[1].size() != 2) begin
            @(negedge clk);
            n++;
        end
        hold[1] = 1'b1;
        n = 0;
        @(negedge clk);
        while (n < 100 && dut.state_q !== IDLE) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 100) begin
            miscompares++;
            $display("FAIL hold_idle: state=%0d, required IDLE", dut.state_q);
        end
        repeat (5) begin
            @(negedge clk);
            vectors++;
            if (req_ready !== '0 || arb_busy !== 1'b1) begin
                miscompares++;
                $display("FAIL hold_locked: ready=%b arb_busy=%b, required ready=0 arb_busy=1", req_ready, arb_busy);
            end
        end
        hold[1] = 1'b0;
        wait_drain("hold");
        check_ptr("hold");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        long_busy = 1'b1;
        push_byte(0, 8'h5A, 1'b1);
        model_append();
        while (n < 100 && dut.state_q !== WAIT_DONE) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 100) begin
            miscompares++;
            $display("FAIL mid_wait_done: state=%0d, required WAIT_DONE", dut.state_q);
        end
        push_byte(3, 8'h3C, 1'b1);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors += 3;
        if (uart_tx_send !== 0 || uart_tx_data !== 0 || grant_idx !== 0 || arb_err !== 0) begin
            miscompares++;
            $display("FAIL mid_outputs: send=%b data=%h idx=%0d err=%b, required all 0",
                     uart_tx_send, uart_tx_data, grant_idx, arb_err);
        end
        if (req_ready !== '0 || arb_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_ready_busy: ready=%b arb_busy=%b, required 0 and 0", req_ready, arb_busy);
        end
        if (dut.state_q !== IDLE || dut.lock_q !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_state: state=%0d lock=%b, required IDLE and 0", dut.state_q, dut.lock_q);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        abort     = 1'b0;
        long_busy = 1'b0;
        m_ptr  = 0;
        m_lock = 0;
        model_append();
        wait_drain("reset_mid");
        check_ptr("reset_mid");
    endtask

    task automatic test_all_valid();
        for (int i = 0; i < NUM_REQ; i++) push_byte(i, 8'hA0 + 8'(i), 1'b1);
        push_byte(0, 8'hA0, 1'b1);
        model_append();
        wait_drain("all_valid");
        check_ptr("all_valid");
    endtask

    task automatic test_timeout();
        int n = 0;
        mute = 1'b1;
        push_byte(0, 8'h77, 1'b1);
        push_byte(1, 8'h78, 1'b1);
        model_append();
        while (n < 50 && uart_tx_send !== 1'b1) begin
            @(negedge clk);
            n++;
        end
`ifdef UART_ARB_TIMEOUT_EN
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (arb_err !== 1'b1 && n < 40);
        mute = 1'b0;
        vectors++;
        if (n != 16) begin
            miscompares++;
            $display("FAIL timeout_cycle: err after %0d cycles, required 16", n);
        end
        @(negedge clk);
        vectors++;
        if (arb_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_pulse: err=%b, required 0", arb_err);
        end
`else
        repeat (30) begin
            @(negedge clk);
            vectors++;
            if (arb_err !== 1'b0 || arb_busy !== 1'b1 || req_ready !== '0 || dut.state_q !== WAIT_BUSY) begin
                miscompares++;
                $display("FAIL no_timeout: err=%b busy=%b ready=%b state=%0d, required 0 1 0 WAIT_BUSY",
                         arb_err, arb_busy, req_ready, dut.state_q);
            end
        end
        mute = 1'b0;
        @(posedge clk);
        #1 uart_tx_busy = 1'b1;
        repeat (2) @(posedge clk);
        #1 uart_tx_busy = 1'b0;
`endif
        wait_drain("timeout");
        check_ptr("timeout");
    endtask

    task automatic test_random();
        int npk, len;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                npk = $urandom_range(0, 2);
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) push_byte(i, 8'($urandom_range(0, 255)), b == len - 1);
                end
            end
            model_append();
            wait_drain("random");
            check_ptr("random");
        end
    endtask

    initial begin : main
        test_reset();
        test_single();
        test_lock_packet();
        test_hold_owner();
        test_reset_mid();
        test_all_valid();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
